game_move_sched: RTL and testbench
==================================

GAME_MOVE_SCHED -- requirements
Module: game_move_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL be the number of buffered move commands (power of two, 2..16).
REQ-002 Parameter MAX_MOVES, default 32, SHALL be the move budget per game (1..255).
REQ-003 Parameter GAP, default 2, SHALL be the number of wait cycles after each move pulse (minimum 1).
REQ-004 Port clock, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port R, input, 1: SHALL be the reset, asynchronous and active-low (asserted when 0).
REQ-006 Port start, input, 1: SHALL be the request to begin a game, sampled each cycle.
REQ-007 Port cmd_valid, input, 1: SHALL indicate that cmd_dir holds a move command.
REQ-008 Port cmd_dir, input, 2: SHALL encode the direction as 00=N, 01=S, 10=E, 11=W.
REQ-009 Port cmd_ready, output, 1: SHALL indicate the FIFO can accept a command.
REQ-010 Port game_R, output, 1: SHALL be the active-high reset driven to the game block.
REQ-011 Ports n, s, e, w, output, 1 each: SHALL be the one-cycle direction pulses driven to the game block.
REQ-012 Ports win, d, input, 1 each: SHALL be the game's win and dead status.
REQ-013 Port busy, output, 1: SHALL be high while a game is running.
REQ-014 Port done, output, 1: SHALL be high while a finished result is held.
REQ-015 Port result, output, 2: SHALL report the outcome as 00=none, 01=win, 10=dead, 11=timeout.
REQ-016 Port move_cnt, output, 8: SHALL count moves issued in the current game.

Function
REQ-017 Command FIFO: a command SHALL be accepted on any cycle where cmd_valid=1 and cmd_ready=1, in any FSM state (preload allowed).
REQ-018 cmd_ready SHALL equal (count < FIFO_DEPTH), from registered count only, with no full-bypass; a simultaneous push and pop SHALL leave count unchanged.
REQ-019 FSM states SHALL be IDLE, RST_GAME, ISSUE, WAIT and DONE.
REQ-020 IDLE/DONE with start=1 -> RST_GAME; this SHALL clear move_cnt and result to 0, SHALL drop done, and SHALL retain FIFO contents. start SHALL be ignored in all other states.
REQ-021 RST_GAME SHALL last exactly 2 cycles with game_R=1, then go to ISSUE.
REQ-022 game_R SHALL be 1 in IDLE and RST_GAME, and 0 in ISSUE, WAIT and DONE.
REQ-023 ISSUE checks, in priority order: win=1 -> DONE with result 01; else d=1 -> DONE with result 10; else move_cnt==MAX_MOVES -> DONE with result 11; else FIFO non-empty -> pop, pulse the matching direction for exactly that cycle, increment move_cnt, go to WAIT; else stay in ISSUE with no pulse (stall, no timeout).
REQ-024 WAIT SHALL last GAP cycles with no pulses; win, or else d, seen in any WAIT cycle SHALL go to DONE with result 01, or else 10, on the next edge; otherwise WAIT returns to ISSUE.
REQ-025 At most one of n/s/e/w SHALL be high in any cycle; all SHALL be 0 outside ISSUE.
REQ-026 busy SHALL be 1 in RST_GAME, ISSUE and WAIT; done SHALL be 1 only in DONE.
REQ-027 move_cnt SHALL saturate at MAX_MOVES and never wrap.

Reset
REQ-028 While R=0: FSM SHALL be IDLE, FIFO empty, game_R=1, n/s/e/w=0, busy=0, done=0, result=00, move_cnt=0.
REQ-029 cmd_ready SHALL be 1 after reset deassertion.
REQ-030 Reset asserted mid-game SHALL abort the game immediately and discard all FIFO contents.

Verification
REQ-031 Preload E,S,W,E,E, then start -> pulses e,s,w,e,e spaced GAP+1 cycles apart; then done=1, result=01, move_cnt=5.
REQ-032 Preload E,S,E, then start -> done=1, result=10, move_cnt=3, and the FIFO is empty.
REQ-033 With MAX_MOVES=4, queue E,W,E,W,E, then start -> 4 pulses, then result=11, move_cnt=4, and one command remains in the FIFO.
REQ-034 Push 5 commands back-to-back in IDLE with FIFO_DEPTH=4 -> cmd_ready=0 after the 4th; the 5th is not accepted.
REQ-035 Pulse start while busy=1, then pull R low mid-WAIT -> the start has no effect; after reset all outputs match REQ-028 and cmd_ready=1.

Source files
------------

// File: rtl/game_move_sched.sv
// Move scheduler: buffers direction commands and plays them into a game block as
// single-cycle pulses, holding the game's reset and collecting its win/dead/timeout outcome.
module game_move_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_MOVES  = 32,
    parameter int GAP        = 2
) (
    input  logic       clock,
    input  logic       R,
    input  logic       start,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_dir,
    output logic       cmd_ready,
    output logic       game_R,
    output logic       n,
    output logic       s,
    output logic       e,
    output logic       w,
    input  logic       win,
    input  logic       d,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic [7:0] move_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_GAME = 3'd1,
        ISSUE    = 3'd2,
        WAIT     = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t             state;
    logic [1:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               rst_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               at_limit;
    logic [1:0]         head;

    // Handshake: a command transfers on every rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends only on the registered count.
    assign cmd_ready  = (count < CNT_W'(FIFO_DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign fifo_empty = (count == '0);
    assign at_limit   = (move_cnt == 8'(MAX_MOVES));
    assign head       = mem[rd_ptr];
    assign pop        = (state == ISSUE) && !win && !d && !at_limit && !fifo_empty;

    assign game_R = (state == IDLE) || (state == RST_GAME);
    assign busy   = (state == RST_GAME) || (state == ISSUE) || (state == WAIT);
    assign done   = (state == DONE);

    // The pulse fires in the same ISSUE cycle that pops the command.
    always_comb begin
        n = 1'b0;
        s = 1'b0;
        e = 1'b0;
        w = 1'b0;
        if (pop) begin
            case (head)
                2'b00:   n = 1'b1;
                2'b01:   s = 1'b1;
                2'b10:   e = 1'b1;
                default: w = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= cmd_dir;
        end
    end

    always_ff @(posedge clock or negedge R) begin
        if (!R) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge R) begin
        if (!R) begin
            state    <= IDLE;
            result   <= 2'b00;
            move_cnt <= 8'd0;
            rst_cnt  <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RST_GAME;
                        move_cnt <= 8'd0;
                        result   <= 2'b00;
                        rst_cnt  <= 1'b0;
                    end
                end
                RST_GAME: begin
                    if (rst_cnt) begin
                        state <= ISSUE;
                    end else begin
                        rst_cnt <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (win) begin
                        state  <= DONE;
                        result <= 2'b01;
                    end else if (d) begin
                        state  <= DONE;
                        result <= 2'b10;
                    end else if (at_limit) begin
                        state  <= DONE;
                        result <= 2'b11;
                    end else if (!fifo_empty) begin
                        move_cnt <= move_cnt + 8'd1;
                        gap_cnt  <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (win) begin
                        state  <= DONE;
                        result <= 2'b01;
                    end else if (d) begin
                        state  <= DONE;
                        result <= 2'b10;
                    end else if (gap_cnt == GAP_W'(GAP - 1)) begin
                        state <= ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_move_sched.sv
// Bench for game_move_sched: two instances (move budget 32 and 4) share one stimulus
// stream and are compared every cycle against a command-queue game model.
module tb_game_move_sched;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic       clock;
    logic       R;
    logic       start;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       win;
    logic       d;

    logic       rdy [2];
    logic       grst [2];
    logic       pn [2];
    logic       ps [2];
    logic       pe [2];
    logic       pw [2];
    logic       bsy [2];
    logic       dn [2];
    logic [1:0] res [2];
    logic [7:0] cnt [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model: one queue of commands and a coarse game picture per instance
    logic [1:0] m_q [2][16];
    int         m_qn [2];
    bit         m_game [2];
    bit         m_held [2];
    int         m_rst [2];
    int         m_gap [2];
    int         m_moves [2];
    logic [1:0] m_res [2];
    bit         m_acc [2];

    bit spacing_on = 1'b0;
    int last_pulse = -1;

    game_move_sched #(.FIFO_DEPTH(DEPTH), .MAX_MOVES(32), .GAP(GAP)) dut0 (
        .clock(clock), .R(R), .start(start), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(rdy[0]), .game_R(grst[0]), .n(pn[0]), .s(ps[0]), .e(pe[0]), .w(pw[0]),
        .win(win), .d(d), .busy(bsy[0]), .done(dn[0]), .result(res[0]), .move_cnt(cnt[0])
    );

    game_move_sched #(.FIFO_DEPTH(DEPTH), .MAX_MOVES(4), .GAP(GAP)) dut1 (
        .clock(clock), .R(R), .start(start), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(rdy[1]), .game_R(grst[1]), .n(pn[1]), .s(ps[1]), .e(pe[1]), .w(pw[1]),
        .win(win), .d(d), .busy(bsy[1]), .done(dn[1]), .result(res[1]), .move_cnt(cnt[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int maxm(input int i);
        return (i == 0) ? 32 : 4;
    endfunction

    function automatic logic [3:0] pulses(input int i);
        return {pn[i], ps[i], pe[i], pw[i]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear(input int i);
        m_qn[i]    = 0;
        m_game[i]  = 1'b0;
        m_held[i]  = 1'b0;
        m_rst[i]   = 0;
        m_gap[i]   = 0;
        m_moves[i] = 0;
        m_res[i]   = 2'b00;
        m_acc[i]   = 1'b0;
    endtask

    task automatic finish_game(input int i, input logic [1:0] r);
        m_game[i] = 1'b0;
        m_held[i] = 1'b1;
        m_res[i]  = r;
    endtask

    task automatic compare(input int i);
        logic [3:0] exp_p;
        bit         exp_grst;
        exp_p = 4'b0000;
        if (m_game[i] && m_rst[i] == 0 && m_gap[i] == 0 && !win && !d
            && m_moves[i] < maxm(i) && m_qn[i] > 0) begin
            exp_p = 4'b1000 >> m_q[i][0];
        end
        exp_grst = (!m_game[i] && !m_held[i]) || (m_game[i] && m_rst[i] > 0);
        chk($sformatf("i%0d cmd_ready", i), 32'(rdy[i]), 32'(m_qn[i] < DEPTH));
        chk($sformatf("i%0d game_R", i), 32'(grst[i]), 32'(exp_grst));
        chk($sformatf("i%0d busy", i), 32'(bsy[i]), 32'(m_game[i]));
        chk($sformatf("i%0d done", i), 32'(dn[i]), 32'(m_held[i]));
        chk($sformatf("i%0d result", i), 32'(res[i]), 32'(m_res[i]));
        chk($sformatf("i%0d move_cnt", i), 32'(cnt[i]), 32'(m_moves[i]));
        chk($sformatf("i%0d pulses", i), 32'(pulses(i)), 32'(exp_p));
    endtask

    task automatic model_advance(input int i);
        m_acc[i] = cmd_valid && (m_qn[i] < DEPTH);
        if (m_game[i]) begin
            if (m_rst[i] > 0) begin
                m_rst[i]--;
            end else if (m_gap[i] > 0) begin
                if (win) finish_game(i, 2'b01);
                else if (d) finish_game(i, 2'b10);
                else m_gap[i]--;
            end else begin
                if (win) finish_game(i, 2'b01);
                else if (d) finish_game(i, 2'b10);
                else if (m_moves[i] == maxm(i)) finish_game(i, 2'b11);
                else if (m_qn[i] > 0) begin
                    for (int k = 0; k < 15; k++) m_q[i][k] = m_q[i][k+1];
                    m_qn[i]--;
                    m_moves[i]++;
                    m_gap[i] = GAP;
                end
            end
        end else if (start) begin
            m_game[i]  = 1'b1;
            m_held[i]  = 1'b0;
            m_rst[i]   = 2;
            m_gap[i]   = 0;
            m_moves[i] = 0;
            m_res[i]   = 2'b00;
        end
        if (m_acc[i]) begin
            m_q[i][m_qn[i]] = cmd_dir;
            m_qn[i]++;
        end
    endtask

    // Inputs are changed at a falling edge; tick checks them and advances one clock.
    task automatic tick();
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!R) model_clear(i);
            compare(i);
        end
        if (spacing_on && pulses(0) != 4'b0000) begin
            if (last_pulse >= 0) chk("pulse spacing", 32'(cyc - last_pulse), 32'(GAP + 1));
            last_pulse = cyc;
        end
        if (R) begin
            for (int i = 0; i < 2; i++) model_advance(i);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 2'b00;
        win       = 1'b0;
        d         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        R = 1'b0;
        tick();
        tick();
        R = 1'b1;
        tick();
    endtask

    task automatic push_cmd(input logic [1:0] dir);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_when_ready(input logic [1:0] dir);
        int budget;
        budget    = 30;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        do begin
            tick();
            budget--;
        end while (!m_acc[0] && budget > 0);
        cmd_valid = 1'b0;
        chk("late push accepted", 32'(m_acc[0]), 32'd1);
    endtask

    initial begin
        int budget;
        int seen;
        for (int i = 0; i < 2; i++) model_clear(i);
        R = 1'b0;
        idle_inputs();
        @(negedge clock);
        tick();
        chk("reset game_R", 32'(grst[0]), 32'd1);
        chk("reset busy", 32'(bsy[0]), 32'd0);
        chk("reset cmd_ready", 32'(rdy[0]), 32'd1);
        R = 1'b1;
        tick();

        // Win after five moves E,S,W,E,E
        do_reset();
        push_cmd(2'b10); push_cmd(2'b01); push_cmd(2'b11); push_cmd(2'b10);
        spacing_on = 1'b1;
        last_pulse = -1;
        pulse_start();
        push_when_ready(2'b10);
        budget = 60;
        while (!m_held[0] && budget > 0) begin
            win = (m_moves[0] == 5) && (m_gap[0] > 0);
            tick();
            budget--;
        end
        win = 1'b0;
        spacing_on = 1'b0;
        chk("win done", 32'(dn[0]), 32'd1);
        chk("win result", 32'(res[0]), 32'd1);
        chk("win move_cnt", 32'(cnt[0]), 32'd5);
        chk("budget4 result", 32'(res[1]), 32'd3);
        chk("budget4 move_cnt", 32'(cnt[1]), 32'd4);

        // Dead after three moves E,S,E
        do_reset();
        push_cmd(2'b10); push_cmd(2'b01); push_cmd(2'b10);
        pulse_start();
        budget = 60;
        while (!m_held[0] && budget > 0) begin
            d = (m_moves[0] == 3) && (m_gap[0] > 0);
            tick();
            budget--;
        end
        d = 1'b0;
        chk("dead done", 32'(dn[0]), 32'd1);
        chk("dead result", 32'(res[0]), 32'd2);
        chk("dead move_cnt", 32'(cnt[0]), 32'd3);
        pulse_start();
        seen = 0;
        repeat (12) begin
            if (pulses(0) != 4'b0000) seen++;
            tick();
        end
        chk("dead fifo empty", 32'(seen), 32'd0);
        chk("restart move_cnt", 32'(cnt[0]), 32'd0);

        // Timeout on the 4-move instance with E,W,E,W,E queued
        do_reset();
        push_cmd(2'b10); push_cmd(2'b11); push_cmd(2'b10); push_cmd(2'b11);
        pulse_start();
        push_when_ready(2'b10);
        repeat (40) tick();
        chk("timeout done", 32'(dn[1]), 32'd1);
        chk("timeout result", 32'(res[1]), 32'd3);
        chk("timeout move_cnt", 32'(cnt[1]), 32'd4);
        chk("stall busy", 32'(bsy[0]), 32'd1);
        pulse_start();
        seen = 0;
        repeat (12) begin
            if (pulses(1) == 4'b0010) seen++;
            tick();
        end
        chk("leftover command", 32'(seen), 32'd1);

        // Five back-to-back pushes into an idle FIFO
        do_reset();
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cmd_dir = 2'(k);
            tick();
            if (k == 3) chk("full after 4", 32'(rdy[0]), 32'd0);
        end
        cmd_valid = 1'b0;
        chk("5th rejected", 32'(rdy[0]), 32'd0);
        pulse_start();
        repeat (20) tick();

        // start while busy, then reset in the middle of a WAIT
        do_reset();
        push_cmd(2'b00); push_cmd(2'b01);
        pulse_start();
        budget = 20;
        while (m_gap[0] == 0 && budget > 0) begin
            tick();
            budget--;
        end
        pulse_start();
        chk("start ignored busy", 32'(bsy[0]), 32'd1);
        R = 1'b0;
        tick();
        chk("abort game_R", 32'(grst[0]), 32'd1);
        chk("abort busy", 32'(bsy[0]), 32'd0);
        chk("abort done", 32'(dn[0]), 32'd0);
        chk("abort result", 32'(res[0]), 32'd0);
        chk("abort move_cnt", 32'(cnt[0]), 32'd0);
        R = 1'b1;
        tick();
        chk("post reset ready", 32'(rdy[0]), 32'd1);
        pulse_start();
        repeat (10) tick();

        // Randomized traffic
        repeat (3000) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_dir   = 2'($urandom_range(0, 3));
            start     = ($urandom_range(0, 19) == 0);
            win       = ($urandom_range(0, 29) == 0);
            d         = ($urandom_range(0, 29) == 0);
            R         = ($urandom_range(0, 299) != 0);
            tick();
        end
        R = 1'b1;
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
